// File: rtl/config_stream_loader_pkg.sv
// Shared definitions for the configuration stream loader: bus defaults,
// FSM state encodings and tile module-select codes.
package config_stream_loader_pkg;

    // Address no tile decodes (tile_id 0xFFFF is never assigned)
    localparam logic [31:0] IDLE_ADDR_DEF = 32'hFFFF_FFFF;
    // Record address that ends a bitstream
    localparam logic [31:0] TERM_ADDR_DEF = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // module_sel values carried in config_addr[31:16]
    localparam logic [15:0] CONFIG_SB      = 16'd7;
    localparam logic [15:0] CONFIG_CB0     = 16'd6;
    localparam logic [15:0] CONFIG_CB1     = 16'd5;
    localparam logic [15:0] CONFIG_COMPUTE = 16'd4;

    // Saturating 16-bit increment for the issued-record counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/config_stream_loader_assembler.sv
// Byte-to-record assembler: keeps the first seven bytes of a record and
// presents the full 64-bit record combined with the byte on the input, so
// the top can act on the completed record on the edge that accepts byte 7.
module cfg_record_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [63:0] o_record,
    output logic        o_last
);

    logic [55:0] r_rec;
    logic [2:0]  r_cnt;

    // Shift bytes in MSB-first; counter wraps 7 -> 0 after the last byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rec <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_shift) begin
            r_rec <= {r_rec[47:0], i_byte};
            r_cnt <= r_cnt + 3'd1;
        end
    end

    assign o_record = {r_rec, i_byte};
    assign o_last   = (r_cnt == 3'd7);

endmodule

// File: rtl/config_stream_loader.sv
// Configuration stream loader: assembles 8-byte {addr,data} records from a
// byte stream and broadcasts each on the tile configuration bus for
// HOLD_CYCLES clocks, parking the bus on IDLE_ADDR otherwise.
module config_stream_loader
    import config_stream_loader_pkg::*;
#(
    parameter int          HOLD_CYCLES = 1,
    parameter logic [31:0] IDLE_ADDR   = IDLE_ADDR_DEF,
    parameter logic [31:0] TERM_ADDR   = TERM_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] write_count
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_hold;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_done;
    logic [15:0] r_write_count;

    logic        w_accept;
    logic        w_shift;
    logic        w_last;
    logic        w_rec_end;
    logic        w_is_term;
    logic        w_hold_done;
    logic [63:0] w_record;

    assign w_accept    = in_valid && in_ready;
    // A start in the same cycle discards the byte
    assign w_shift     = w_accept && !start;
    assign w_rec_end   = w_shift && w_last;
    assign w_is_term   = (w_record[63:32] == TERM_ADDR);
    assign w_hold_done = (r_state == ST_ISSUE) && (r_hold == HOLD_LAST);

    cfg_record_assembler u_asm (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (start),
        .i_shift  (w_shift),
        .i_byte   (in_data),
        .o_record (w_record),
        .o_last   (w_last)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state: start overrides everything
    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD:  if (w_rec_end) w_state_nxt = w_is_term ? ST_DONE : ST_ISSUE;
                ST_ISSUE: if (w_hold_done) w_state_nxt = ST_LOAD;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    // Combinational handshake/status decode
    always_comb begin
        in_ready = (r_state == ST_LOAD);
        busy     = (r_state == ST_LOAD) || (r_state == ST_ISSUE);
    end

    // Bus drive, hold counter and done flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr <= IDLE_ADDR;
            r_data <= '0;
            r_hold <= '0;
            r_done <= 1'b0;
        end else if (start) begin
            r_addr <= IDLE_ADDR;
            r_data <= '0;
            r_hold <= '0;
            r_done <= 1'b0;
        end else if (r_state == ST_LOAD && w_rec_end) begin
            r_hold <= '0;
            if (w_is_term) begin
                r_done <= 1'b1;
            end else begin
                r_addr <= w_record[63:32];
                r_data <= w_record[31:0];
            end
        end else if (r_state == ST_ISSUE) begin
            if (w_hold_done) begin
                r_addr <= IDLE_ADDR;
                r_data <= '0;
                r_hold <= '0;
            end else begin
                r_hold <= r_hold + 4'd1;
            end
        end
    end

    // Issued-record counter, bumped when a record leaves the bus
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           r_write_count <= '0;
        else if (start)       r_write_count <= '0;
        else if (w_hold_done) r_write_count <= sat_inc16(r_write_count);
    end

    assign config_addr = r_addr;
    assign config_data = r_data;
    assign done        = r_done;
    assign write_count = r_write_count;

endmodule

// File: tb/tb_config_stream_loader.sv
// Directed bench: one loader with HOLD_CYCLES=1 and one with HOLD_CYCLES=3
// share the stimulus; `sel` picks the instance being exercised and checked.
module tb_config_stream_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        sel = 1'b0;

    logic        rdy1, rdy3, busy1, busy3, done1, done3;
    logic [31:0] addr1, addr3, data1, data3;
    logic [15:0] wc1, wc3;

    int errs = 0;
    int checks = 0;
    logic bad_park = 1'b0;

    always #5 clk = ~clk;

    config_stream_loader #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(rdy1), .config_addr(addr1),
        .config_data(data1), .busy(busy1), .done(done1), .write_count(wc1)
    );

    config_stream_loader #(.HOLD_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(rdy3), .config_addr(addr3),
        .config_data(data3), .busy(busy3), .done(done3), .write_count(wc3)
    );

    wire        w_rdy  = sel ? rdy3  : rdy1;
    wire        w_busy = sel ? busy3 : busy1;
    wire        w_done = sel ? done3 : done1;
    wire [31:0] w_addr = sel ? addr3 : addr1;
    wire [31:0] w_data = sel ? data3 : data1;
    wire [15:0] w_wc   = sel ? wc3   : wc1;

    // The parked address must never be seen with a nonzero payload
    always @(negedge clk) begin
        if (reset && addr1 == 32'hFFFF_FFFF && data1 != 32'h0) bad_park = 1'b1;
        if (reset && addr3 == 32'hFFFF_FFFF && data3 != 32'h0) bad_park = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; holds the byte until accepted, returns at the
    // negedge after the accepting edge with in_valid dropped.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!w_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 64'(n), 64'(0));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_rec(input logic [31:0] a, input logic [31:0] d, input bit gaps);
        logic [63:0] r;
        r = {a, d};
        for (int i = 7; i >= 0; i--) begin
            send_byte(r[i*8 +: 8]);
            if (gaps && i != 0) @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        // ---- reset state ----
        @(negedge clk);
        chk("rst_addr", 64'(w_addr), 64'hFFFF_FFFF);
        chk("rst_data", 64'(w_data), 64'h0);
        chk("rst_ready", 64'(w_rdy), 64'h0);
        chk("rst_busy", 64'(w_busy), 64'h0);
        chk("rst_done", 64'(w_done), 64'h0);
        chk("rst_wc", 64'(w_wc), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_ready", 64'(w_rdy), 64'h0);

        // ---- single record, HOLD_CYCLES=1 ----
        sel = 1'b0;
        pulse_start();
        chk("load_ready", 64'(w_rdy), 64'h1);
        chk("load_busy", 64'(w_busy), 64'h1);
        send_rec(32'h0007_0003, 32'h0000_002A, 1'b0);
        chk("s1_addr", 64'(w_addr), 64'h0007_0003);
        chk("s1_data", 64'(w_data), 64'h2A);
        chk("s1_ready", 64'(w_rdy), 64'h0);
        chk("s1_wc_pre", 64'(w_wc), 64'h0);
        @(negedge clk);
        chk("s1_park", 64'(w_addr), 64'hFFFF_FFFF);
        chk("s1_parkd", 64'(w_data), 64'h0);
        chk("s1_wc", 64'(w_wc), 64'h1);
        chk("s1_ready2", 64'(w_rdy), 64'h1);

        // ---- terminator ----
        pulse_start();
        chk("t_wc_clr", 64'(w_wc), 64'h0);
        send_rec(32'h0004_0001, 32'h0000_0003, 1'b0);
        chk("t_addr", 64'(w_addr), 64'h0004_0001);
        chk("t_data", 64'(w_data), 64'h3);
        send_rec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("t_done", 64'(w_done), 64'h1);
        chk("t_ready", 64'(w_rdy), 64'h0);
        chk("t_busy", 64'(w_busy), 64'h0);
        chk("t_wc", 64'(w_wc), 64'h1);
        chk("t_park", 64'(w_addr), 64'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        chk("t_done_hold", 64'(w_done), 64'h1);
        chk("t_wc_hold", 64'(w_wc), 64'h1);

        // ---- throttled input, HOLD_CYCLES=3 ----
        sel = 1'b1;
        pulse_start();
        chk("th_done_clr", 64'(w_done), 64'h0);
        send_rec(32'h1122_3344, 32'h5566_7788, 1'b1);
        for (int c = 0; c < 3; c++) begin
            chk("th1_addr", 64'(w_addr), 64'h1122_3344);
            chk("th1_data", 64'(w_data), 64'h5566_7788);
            @(negedge clk);
        end
        chk("th1_park", 64'(w_addr), 64'hFFFF_FFFF);
        chk("th1_wc", 64'(w_wc), 64'h1);
        send_rec(32'h0006_0002, 32'hDEAD_BEEF, 1'b1);
        for (int c = 0; c < 3; c++) begin
            chk("th2_addr", 64'(w_addr), 64'h0006_0002);
            chk("th2_data", 64'(w_data), 64'hDEAD_BEEF);
            @(negedge clk);
        end
        chk("th2_park", 64'(w_addr), 64'hFFFF_FFFF);
        chk("th2_wc", 64'(w_wc), 64'h2);

        // ---- abort during 2nd ISSUE cycle ----
        pulse_start();
        send_rec(32'h0005_0009, 32'h0000_0001, 1'b0);
        chk("ab_issue", 64'(w_addr), 64'h0005_0009);
        @(negedge clk);
        pulse_start();
        chk("ab_park", 64'(w_addr), 64'hFFFF_FFFF);
        chk("ab_data", 64'(w_data), 64'h0);
        chk("ab_wc", 64'(w_wc), 64'h0);
        chk("ab_ready", 64'(w_rdy), 64'h1);
        chk("ab_busy", 64'(w_busy), 64'h1);
        @(negedge clk);
        chk("ab_wc2", 64'(w_wc), 64'h0);
        send_rec(32'h0007_0001, 32'h0000_0077, 1'b0);
        chk("ab_next_addr", 64'(w_addr), 64'h0007_0001);
        chk("ab_next_data", 64'(w_data), 64'h77);
        repeat (3) @(negedge clk);
        chk("ab_next_wc", 64'(w_wc), 64'h1);

        // ---- async reset mid-record, HOLD_CYCLES=1 ----
        sel = 1'b0;
        pulse_start();
        send_rec(32'h0004_0002, 32'h0000_0011, 1'b0);
        @(negedge clk);
        chk("rr_wc_pre", 64'(w_wc), 64'h1);
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
        #2 reset = 1'b0;
        #1;
        chk("rr_addr", 64'(w_addr), 64'hFFFF_FFFF);
        chk("rr_wc", 64'(w_wc), 64'h0);
        chk("rr_ready", 64'(w_rdy), 64'h0);
        chk("rr_busy", 64'(w_busy), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        pulse_start();
        send_rec(32'h0004_00AB, 32'h1234_5678, 1'b0);
        chk("rr_new_addr", 64'(w_addr), 64'h0004_00AB);
        chk("rr_new_data", 64'(w_data), 64'h1234_5678);
        // reset while the record is on the bus parks it before the next edge
        #1 reset = 1'b0;
        #1;
        chk("ri_addr", 64'(w_addr), 64'hFFFF_FFFF);
        chk("ri_data", 64'(w_data), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // ---- write_count saturation ----
        pulse_start();
        force dut1.r_write_count = 16'hFFFE;
        @(negedge clk);
        release dut1.r_write_count;
        @(negedge clk);
        chk("sat_init", 64'(w_wc), 64'hFFFE);
        for (int k = 0; k < 3; k++) begin
            send_rec(32'h0005_0010 + 32'(k), 32'hC0DE_0000 + 32'(k), 1'b0);
            chk("sat_addr", 64'(w_addr), 64'(32'h0005_0010 + 32'(k)));
            chk("sat_data", 64'(w_data), 64'(32'hC0DE_0000 + 32'(k)));
            @(negedge clk);
            chk("sat_wc", 64'(w_wc), 64'hFFFF);
        end

        chk("park_payload", 64'(bad_park), 64'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
